// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory load/store unit.
// Size codes, FSM states and latency bounds.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 8;
  localparam int CNT_W   = 3;

endpackage

// File: rtl/data_mem_lsu_align.sv
// Byte-lane steering: misalign flag, byte enables, store data
// replication and load extraction/extension. Pure combinational.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_uns,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wd,
  input  logic [31:0] i_raw,
  output logic        o_misalign,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_sh;

  assign w_sh = i_raw >> {i_off, 3'b000};

  always_comb begin
    o_misalign = 1'b0;
    o_be       = 4'b0000;
    o_wdata    = '0;
    o_rdata    = '0;
    unique case (1'b1)
      (i_size == SZ_B): begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wd[7:0]}};
        o_rdata = i_uns ? {24'b0, w_sh[7:0]}
                        : {{24{w_sh[7]}}, w_sh[7:0]};
      end
      (i_size == SZ_H): begin
        o_misalign = i_off[0];
        o_be       = 4'b0011 << i_off;
        o_wdata    = {2{i_wd[15:0]}};
        o_rdata    = i_uns ? {16'b0, w_sh[15:0]}
                           : {{16{w_sh[15]}}, w_sh[15:0]};
      end
      (i_size == SZ_W): begin
        o_misalign = (i_off != 2'b00);
        o_be       = 4'b1111;
        o_wdata    = i_wd;
        o_rdata    = i_raw;
      end
      default: o_misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Data memory with load/store front end and configurable latency.
// REQ/READY in; VALID/RD/FAULT out; byte-enabled word array.
module data_mem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ,
  input  logic        WE,
  input  logic [1:0]  SIZE,
  input  logic        UNS,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic        READY,
  output logic        VALID,
  output logic [31:0] RD,
  output logic        FAULT
);

  localparam int LAT_C = (LATENCY < LAT_MIN) ? LAT_MIN :
                         (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;
  localparam bit LAT1  = (LAT_C == 1);
  localparam int DEPTH = 1 << (ADDR_W - 2);
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'((LAT_C > 1) ? LAT_C - 2 : 0);

  state_e             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_we, r_uns, r_fault;
  logic [1:0]         r_size;
  logic [31:0]        r_a, r_wd, r_rd;
  logic [31:0]        r_mem [DEPTH];

  logic               w_accept, w_commit, w_fault, w_oob;
  logic               w_we, w_uns, w_misalign;
  logic [1:0]         w_size;
  logic [31:0]        w_a, w_wd, w_raw, w_wdata, w_rdata;
  logic [3:0]         w_be;
  logic [ADDR_W-3:0]  w_idx;

  assign READY    = (r_state != ST_WAIT);
  assign VALID    = (r_state == ST_RESP);
  assign RD       = r_rd;
  assign FAULT    = r_fault;
  assign w_accept = REQ && READY;

  // With single-cycle latency the access happens on the accept
  // edge itself, so it must use the live request fields.
  assign w_we   = LAT1 ? WE   : r_we;
  assign w_size = LAT1 ? SIZE : r_size;
  assign w_uns  = LAT1 ? UNS  : r_uns;
  assign w_a    = LAT1 ? A    : r_a;
  assign w_wd   = LAT1 ? WD   : r_wd;

  assign w_commit = LAT1 ? w_accept
                         : (r_state == ST_WAIT && r_cnt == '0);
  assign w_idx    = w_a[ADDR_W-1:2];
  assign w_raw    = r_mem[w_idx];
  assign w_oob    = ((w_a >> ADDR_W) != '0);
  assign w_fault  = w_misalign || w_oob;

  dmem_lane_align u_align (
    .i_size     (w_size),
    .i_uns      (w_uns),
    .i_off      (w_a[1:0]),
    .i_wd       (w_wd),
    .i_raw      (w_raw),
    .o_misalign (w_misalign),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_rdata    (w_rdata)
  );

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    unique case (r_state)
      ST_IDLE, ST_RESP: begin
        if (w_accept) begin
          w_next    = LAT1 ? ST_RESP : ST_WAIT;
          w_cnt_nxt = CNT_INIT;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) w_next = ST_RESP;
        else             w_cnt_nxt = r_cnt - 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_size  <= SZ_B;
      r_uns   <= 1'b0;
      r_a     <= '0;
      r_wd    <= '0;
      r_fault <= 1'b0;
      r_rd    <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we   <= WE;
        r_size <= SIZE;
        r_uns  <= UNS;
        r_a    <= A;
        r_wd   <= WD;
      end
      if (w_commit) begin
        r_fault <= w_fault;
        r_rd    <= (w_fault || w_we) ? '0 : w_rdata;
      end
    end
  end

  // Storage is not reset; RST_N gates the write so a request
  // presented while in reset can never commit.
  always_ff @(posedge CLK) begin
    if (RST_N && w_commit && w_we && !w_fault) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Parametrised data memory with a load/store front end for the single-cycle core's successor datapath. It accepts one byte/halfword/word request at a time over a REQ/READY handshake, applies a configurable access latency, and performs byte-lane steering on stores and sign/zero extension on loads. It reports misaligned or out-of-range accesses as a fault instead of corrupting memory. It replaces the fixed 256-word, word-only, combinational-read data memory.

## Interface
- ADDR_W, 10: byte-address bits decoded; depth = 2^(ADDR_W-2) words
- LATENCY, 1: cycles from acceptance edge to VALID; legal range 1..8
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- REQ  in  1  request present
- WE  in  1  1 = store, 0 = load
- SIZE  in  2  00 byte, 01 half, 10 word, 11 illegal
- UNS  in  1  load zero-extends when 1; ignored for stores and words
- A  in  32  byte address
- WD  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- READY  out  1  request can be accepted this cycle
- VALID  out  1  one-cycle response strobe
- RD  out  32  load result, extended; 0 for stores and faults
- FAULT  out  1  qualifies VALID: request was rejected

## Operation
- Acceptance: REQ && READY at a rising edge; request fields (WE, SIZE, UNS, A, WD) are registered at that edge and later input changes are ignored.
- FSM states:
  - IDLE (READY=1, VALID=0)
  - WAIT (READY=0, VALID=0, down-counter running)
  - RESP (READY=1, VALID=1)
- Transitions:
  - IDLE/RESP + accept: LATENCY=1 goes to RESP; otherwise goes to WAIT with cnt=LATENCY-2.
  - WAIT with cnt=0: goes to RESP; otherwise cnt decrements.
  - RESP without accept: goes to IDLE.
- Fault is checked on the registered request:
  - SIZE=11
  - half with A[0]=1
  - word with A[1:0]≠00
  - A[31:ADDR_W]≠0
- A faulting request still takes LATENCY cycles. It responds VALID=1, FAULT=1, RD=0, and memory is untouched.
- Store: byte lane = A[1:0]. Byte enables:
  - byte: 1<<A[1:0]
  - half: 0011<<A[1:0]
  - word: 1111
- Store data is replicated across lanes (byte ×4, half ×2). Only enabled bytes are written.
- Load: a word is read at A[ADDR_W-1:2]. The selected byte/half is shifted to bit 0, then sign-extended (UNS=0) or zero-extended (UNS=1).
- Memory array is not reset; contents are undefined until written.

## Timing
- Reset values: state IDLE, READY=1, VALID=0, FAULT=0, RD=0, cnt=0.
- Request accepted at edge k:
  - Memory access (write commit or read capture into RD) happens at edge k+LATENCY-1.
  - VALID/FAULT/RD are held in the cycle after that edge, for exactly one cycle.
- Back-to-back: a request accepted in the RESP cycle starts immediately.
  - Throughput is one request per LATENCY cycles.
  - The new request sees the previous store's data.
- RD/FAULT keep their last response value while VALID=0. RD is cleared to 0 by a store or fault response.
- Reset asserted mid-operation: returns to IDLE immediately. An uncommitted store is discarded. No VALID is produced for the aborted request.
- Only one request is outstanding; READY=0 in WAIT is the only backpressure.

## Structure
- Package dmem_pkg:
  - SIZE encodings: SZ_B, SZ_H, SZ_W
  - FSM state enum: ST_IDLE, ST_WAIT, ST_RESP
  - LATENCY range constants
- Sub-module dmem_lane_align (combinational): takes SIZE/UNS/A[1:0]/WD/raw word. Produces the misalign flag, byte enables, steered store word and extended load value.
- Top level holds the FSM, counter, request register and the byte-enabled storage array.

## Test plan
- LATENCY=1: store word 0xDEADBEEF at 0x10, then load word at 0x10 -> VALID one cycle after each accept, RD=0xDEADBEEF, FAULT=0.
- Store byte 0x80 at 0x13 over 0x11223344, then load byte signed and unsigned at 0x13 -> RD=0xFFFFFF80 / 0x00000080; word at 0x10 reads 0x80223344.
- Misaligned requests:
  - half load at 0x21 -> FAULT=1, RD=0
  - word store at 0x22 of 0xFFFFFFFF -> FAULT=1; a subsequent word load at 0x20 returns the prior value
  - SIZE=11 -> FAULT=1
- LATENCY=4: back-to-back requests with REQ held high -> READY low for 3 cycles after each accept, VALID exactly every 4 cycles, data ordered.
- Out of range (A=0x400, ADDR_W=10) -> FAULT=1. RST_N pulsed low while in WAIT of a store -> IDLE, no VALID, location unchanged.
